// File: rtl/ctrl_exposure_seq.sv
// Frame sequencer for the camera controller: erase, timed exposure, then a two-row
// readout with ADC strobes. All outputs are registered; reset is asynchronous active-high.
module ctrl_exposure_seq #(
  parameter int unsigned EXP_UNIT_CYCLES = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Init,
  input  logic [4:0] i_Exp_time,
  output logic [1:0] o_Main_FSM,
  output logic       o_Erase,
  output logic       o_Expose,
  output logic       o_NRE_1,
  output logic       o_NRE_2,
  output logic       o_ADC
);

  localparam int unsigned CntW = $clog2(30 * EXP_UNIT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StExposure = 2'b01,
    StReadout  = 2'b10
  } state_e;

  state_e          state_q;
  logic [4:0]      exp_n_q;
  logic [CntW-1:0] exp_cnt_q;
  logic [CntW-1:0] exp_limit;
  logic [2:0]      rd_idx_q;
  logic [2:0]      rd_nxt;

  assign exp_limit  = CntW'(32'(exp_n_q) * EXP_UNIT_CYCLES);
  assign rd_nxt     = rd_idx_q + 3'd1;
  assign o_Main_FSM = state_q;

  function automatic logic [4:0] clamp_exp(input logic [4:0] t);
    if (t < 5'd2) return 5'd2;
    if (t > 5'd30) return 5'd30;
    return t;
  endfunction

  // Strobe pattern per readout index, packed as {nre_1, nre_2, adc}.
  function automatic logic [2:0] rd_strobes(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd2: return 3'b010;
      3'd1:       return 3'b011;
      3'd4, 3'd6: return 3'b100;
      3'd5:       return 3'b101;
      default:    return 3'b110;
    endcase
  endfunction

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= StIdle;
      exp_n_q   <= '0;
      exp_cnt_q <= '0;
      rd_idx_q  <= '0;
      o_Erase   <= 1'b1;
      o_Expose  <= 1'b0;
      o_NRE_1   <= 1'b1;
      o_NRE_2   <= 1'b1;
      o_ADC     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          o_NRE_1 <= 1'b1;
          o_NRE_2 <= 1'b1;
          o_ADC   <= 1'b0;
          if (i_Init) begin
            state_q   <= StExposure;
            exp_n_q   <= clamp_exp(i_Exp_time);
            // Counts elapsed exposure cycles; cycle 1 is the one right after this edge.
            exp_cnt_q <= CntW'(1);
            o_Erase   <= 1'b0;
            o_Expose  <= 1'b1;
          end else begin
            o_Erase  <= 1'b1;
            o_Expose <= 1'b0;
          end
        end
        StExposure: begin
          if (exp_cnt_q >= exp_limit) begin
            state_q  <= StReadout;
            rd_idx_q <= 3'd0;
            o_Expose <= 1'b0;
            {o_NRE_1, o_NRE_2, o_ADC} <= rd_strobes(3'd0);
          end else begin
            exp_cnt_q <= exp_cnt_q + CntW'(1);
          end
        end
        StReadout: begin
          if (rd_idx_q == 3'd7) begin
            state_q  <= StIdle;
            rd_idx_q <= 3'd0;
            o_Erase  <= 1'b1;
            o_NRE_1  <= 1'b1;
            o_NRE_2  <= 1'b1;
            o_ADC    <= 1'b0;
          end else begin
            rd_idx_q <= rd_nxt;
            {o_NRE_1, o_NRE_2, o_ADC} <= rd_strobes(rd_nxt);
          end
        end
        default: begin
          state_q  <= StIdle;
          rd_idx_q <= 3'd0;
          o_Erase  <= 1'b1;
          o_Expose <= 1'b0;
          o_NRE_1  <= 1'b1;
          o_NRE_2  <= 1'b1;
          o_ADC    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_exposure_seq.sv
// Bench for ctrl_exposure_seq: scenario tasks plus randomized traffic, checked cycle by
// cycle against a schedule-queue model of the frame timeline.
module tb_ctrl_exposure_seq;

  localparam int unsigned Unit = 1;
  // Packed as {main[1:0], erase, expose, nre_1, nre_2, adc}.
  localparam logic [6:0] IdleVec = 7'b00_1_0_1_1_0;
  localparam logic [6:0] ExpVec  = 7'b01_0_1_1_1_0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic [4:0] exp_time = 5'd0;
  logic [1:0] main_fsm;
  logic       erase, expose, nre_1, nre_2, adc;
  logic [6:0] dut_vec;

  int checks = 0;
  int errors = 0;

  logic [6:0] model_q[$];
  logic [6:0] model_cur = IdleVec;

  ctrl_exposure_seq #(.EXP_UNIT_CYCLES(Unit)) dut (
    .i_Clock   (clk),
    .i_Reset   (rst),
    .i_Init    (init),
    .i_Exp_time(exp_time),
    .o_Main_FSM(main_fsm),
    .o_Erase   (erase),
    .o_Expose  (expose),
    .o_NRE_1   (nre_1),
    .o_NRE_2   (nre_2),
    .o_ADC     (adc)
  );

  always #5 clk = ~clk;

  assign dut_vec = {main_fsm, erase, expose, nre_1, nre_2, adc};

  // Readout: two rows of four slots; a row's NRE is low for three slots, ADC in the second.
  function automatic logic [6:0] readout_vec(input int i);
    int   row;
    int   phase;
    logic n1, n2, a;
    row   = i / 4;
    phase = i % 4;
    n1    = !(row == 0 && phase < 3);
    n2    = !(row == 1 && phase < 3);
    a     = (phase == 1);
    return {2'b10, 1'b0, 1'b0, n1, n2, a};
  endfunction

  // Advance one clock edge; returns the expected output vector sampled 1 time unit later.
  task automatic step(output logic [6:0] exp_v);
    int n;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_cur = IdleVec;
    end else begin
      if (model_cur[6:5] == 2'b00 && init === 1'b1) begin
        n = (exp_time < 2) ? 2 : (exp_time > 30) ? 30 : int'(exp_time);
        repeat (n * Unit) model_q.push_back(ExpVec);
        for (int i = 0; i < 8; i++) model_q.push_back(readout_vec(i));
      end
      model_cur = (model_q.size() > 0) ? model_q.pop_front() : IdleVec;
    end
    #1 exp_v = model_cur;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    #2 rst = 1'b1;
    init = 1'b0;
    #1 checks++;
    if (dut_vec !== IdleVec) begin
      errors++;
      $display("FAIL reset_async got %b want %b", dut_vec, IdleVec);
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 3) rst = 1'b0;
      step(e);
      checks++;
      if (dut_vec !== e || e !== IdleVec) begin
        errors++;
        $display("FAIL reset cyc %0d got %b want %b", c, dut_vec, IdleVec);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] e;
    int         n_exp, n_rd, n_adc;
    exp_time = 5'd5;
    init = 1'b1;
    n_exp = 0; n_rd = 0; n_adc = 0;
    for (int c = 0; c < 16; c++) begin
      step(e);
      init = 1'b0;
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL basic cyc %0d got %b want %b", c, dut_vec, e);
      end
      n_exp += int'(expose);
      n_rd  += int'(main_fsm == 2'b10);
      n_adc += int'(adc);
    end
    checks++;
    if (n_exp != 5 || n_rd != 8 || n_adc != 2) begin
      errors++;
      $display("FAIL basic_counts got exp=%0d rd=%0d adc=%0d want 5 8 2", n_exp, n_rd, n_adc);
    end
    checks++;
    if (main_fsm !== 2'b00 || erase !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle got main=%b erase=%b want 00 1", main_fsm, erase);
    end
  endtask

  task automatic test_clamp();
    logic [6:0] e;
    int         tv[5] = '{0, 31, 30, 1, 2};
    int         want[5] = '{2, 30, 30, 2, 2};
    int         n_exp;
    for (int k = 0; k < 5; k++) begin
      exp_time = 5'(tv[k]);
      init = 1'b1;
      n_exp = 0;
      for (int c = 0; c < 42; c++) begin
        step(e);
        init = 1'b0;
        checks++;
        if (dut_vec !== e) begin
          errors++;
          $display("FAIL clamp t=%0d cyc %0d got %b want %b", tv[k], c, dut_vec, e);
        end
        n_exp += int'(expose);
      end
      checks++;
      if (n_exp != want[k]) begin
        errors++;
        $display("FAIL clamp_len t=%0d got %0d want %0d", tv[k], n_exp, want[k]);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [6:0] e;
    logic [1:0] prev;
    int         n_exp, starts;
    exp_time = 5'd5;
    init = 1'b1;
    n_exp = 0; starts = 0;
    prev = main_fsm;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3) begin exp_time = 5'd20; init = 1'b1; end
      if (c == 4 || c == 10 || c == 2) init = 1'b0;
      if (c == 9) init = 1'b1;
      step(e);
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL ignored cyc %0d got %b want %b", c, dut_vec, e);
      end
      n_exp  += int'(expose);
      starts += int'(prev == 2'b00 && main_fsm == 2'b01);
      prev = main_fsm;
    end
    init = 1'b0;
    checks++;
    if (n_exp != 5 || starts != 1) begin
      errors++;
      $display("FAIL ignored_counts got exp=%0d starts=%0d want 5 1", n_exp, starts);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    logic [1:0] prev;
    int         idles, starts;
    exp_time = 5'd3;
    init = 1'b1;
    idles = 0; starts = 0;
    prev = main_fsm;
    for (int c = 1; c <= 35; c++) begin
      step(e);
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL b2b cyc %0d got %b want %b", c, dut_vec, e);
      end
      if (main_fsm == 2'b00) begin
        idles++;
        checks++;
        if (erase !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap_erase cyc %0d got %b want 1", c, erase);
        end
      end
      starts += int'(prev == 2'b00 && main_fsm == 2'b01);
      prev = main_fsm;
    end
    init = 1'b0;
    checks++;
    if (idles != 2 || starts != 3) begin
      errors++;
      $display("FAIL b2b_counts got idle=%0d starts=%0d want 2 3", idles, starts);
    end
    repeat (3) step(e);
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    int         pre[2] = '{3, 7};
    int         et[2] = '{10, 2};
    for (int k = 0; k < 2; k++) begin
      exp_time = 5'(et[k]);
      init = 1'b1;
      for (int c = 0; c <= pre[k]; c++) begin
        step(e);
        init = 1'b0;
        checks++;
        if (dut_vec !== e) begin
          errors++;
          $display("FAIL arst_pre k=%0d cyc %0d got %b want %b", k, c, dut_vec, e);
        end
      end
      #2 rst = 1'b1;
      model_q.delete();
      model_cur = IdleVec;
      #1 checks++;
      if (dut_vec !== IdleVec) begin
        errors++;
        $display("FAIL arst_immediate k=%0d got %b want %b", k, dut_vec, IdleVec);
      end
      for (int c = 0; c < 7; c++) begin
        if (c == 2) rst = 1'b0;
        step(e);
        checks++;
        if (dut_vec !== e || e !== IdleVec) begin
          errors++;
          $display("FAIL arst_post k=%0d cyc %0d got %b want %b", k, c, dut_vec, IdleVec);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    for (int c = 0; c < 600; c++) begin
      exp_time = 5'($urandom);
      init = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(e);
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", c, dut_vec, e);
      end
      checks++;
      if ((!nre_1 && !nre_2) || (adc && (nre_1 == nre_2)) || (erase && expose)) begin
        errors++;
        $display("FAIL random_invariant cyc %0d got %b want exclusive strobes", c, dut_vec);
      end
    end
    rst = 1'b0;
    init = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_ignored_inputs();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
